// File: rtl/alu16_mul_seq.sv
// Shift-and-add 16x16 multiplier controller (low 16 bits kept) that borrows an
// external combinational alu16 for every add and shift it performs.
module alu16_mul_seq #(
  parameter int          W      = 16,
  parameter logic [2:0]  OP_ADD = 3'b000,
  parameter logic [2:0]  OP_SHL = 3'b101
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         ovf,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_op,
  output logic         alu_cin,
  input  logic [W-1:0] alu_y,
  input  logic         alu_cout
);

  // Handshake: start is sampled only in S_IDLE; done is a one-cycle pulse and
  // result/ovf hold from that cycle until the next accepted start.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADD   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t       state;
  logic [W-1:0] p;
  logic [W-1:0] m;
  logic [W-1:0] q;
  logic [W-1:0] q_next;

  assign q_next = q >> 1;

  // ALU pins are a pure decode of the current state and datapath registers.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_op  = OP_ADD;
    alu_cin = 1'b0;
    case (state)
      S_ADD: begin
        alu_a  = p;
        alu_b  = m;
        alu_op = OP_ADD;
      end
      S_SHIFT: begin
        alu_a  = m;
        alu_b  = '0;
        alu_op = OP_SHL;
      end
      default: begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = OP_ADD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      p      <= '0;
      m      <= '0;
      q      <= '0;
      result <= '0;
      ovf    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            m   <= op_a;
            q   <= op_b;
            p   <= '0;
            ovf <= 1'b0;
            if (op_b == '0) begin
              state  <= S_DONE;
              result <= '0;
              done   <= 1'b1;
              busy   <= 1'b0;
            end else if (op_b[0]) begin
              state <= S_ADD;
              busy  <= 1'b1;
            end else begin
              state <= S_SHIFT;
              busy  <= 1'b1;
            end
          end
        end
        S_ADD: begin
          p     <= alu_y;
          ovf   <= ovf | alu_cout;
          state <= S_SHIFT;
        end
        S_SHIFT: begin
          m <= alu_y;
          q <= q_next;
          // A bit shifted out of M only matters if a later add would use it.
          ovf <= ovf | (alu_cout & (q_next != '0));
          if (q_next == '0) begin
            state  <= S_DONE;
            result <= p;
            done   <= 1'b1;
            busy   <= 1'b0;
          end else if (q[1]) begin
            state <= S_ADD;
          end else begin
            state <= S_SHIFT;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu16_mul_seq.sv
// Bench for alu16_mul_seq: behavioural alu16 on the ALU pins, queue-based
// scoreboard for results/latency and for the expected ALU step sequence.
module tb_alu16_mul_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        ovf;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_op;
  logic        alu_cin;
  logic [15:0] alu_y;
  logic        alu_cout;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // {due cycle[31:0], ovf, result[15:0]}
  logic [48:0] exp_q[$];
  // {op[2:0], a[15:0], b[15:0]} for every busy cycle
  logic [34:0] alu_q[$];
  logic [15:0] prev_res = 16'd0;
  logic        prev_ovf = 1'b0;
  logic [48:0] me;
  logic [34:0] ae;

  alu16_mul_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result), .ovf(ovf),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
    .alu_y(alu_y), .alu_cout(alu_cout)
  );

  // Clock / cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural alu16 (only the ops this controller uses)
  always_comb begin
    {alu_cout, alu_y} = 17'd0;
    case (alu_op)
      3'b000:  {alu_cout, alu_y} = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, alu_cin};
      3'b101:  {alu_cout, alu_y} = {alu_a[15], alu_a[14:0], 1'b0};
      default: {alu_cout, alu_y} = 17'd0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: compares every busy cycle's ALU drive and every done pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) begin
        if (alu_q.size() == 0) begin
          n_checks++;
          $display("FAIL alu_step_extra: got op %0h a %0h with no step expected", alu_op, alu_a);
        end else begin
          ae = alu_q.pop_front();
          check("alu_op", 32'(alu_op), 32'(ae[34:32]));
          check("alu_a", 32'(alu_a), 32'(ae[31:16]));
          check("alu_b", 32'(alu_b), 32'(ae[15:0]));
        end
        check("alu_cin", 32'(alu_cin), 32'(prev_ovf & 1'b0));
        check("result_hold_busy", 32'(result), 32'(prev_res));
      end else if (!done) begin
        check("idle_alu_a", 32'(alu_a), 32'd0);
        check("idle_alu_b", 32'(alu_b), 32'd0);
        check("idle_alu_op", 32'(alu_op), 32'd0);
        check("idle_alu_cin", 32'(alu_cin), 32'd0);
        check("idle_result", 32'(result), 32'(prev_res));
        check("idle_ovf", 32'(ovf), 32'(prev_ovf));
      end
      if (done) begin
        check("busy_in_done", 32'(busy), 32'd0);
        check("alu_steps_left", 32'(alu_q.size()), 32'd0);
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL done_unexpected: got done=1 expected no done (t=%0t)", $time);
        end else begin
          me = exp_q.pop_front();
          check("result", 32'(result), 32'(me[15:0]));
          check("ovf", 32'(ovf), 32'(me[16]));
          check("done_cycle", 32'(cyc), me[48:17]);
          prev_res = me[15:0];
          prev_ovf = me[16];
        end
      end
    end
  end

  // Driver: reference model computes product, overflow, ALU steps and latency.
  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] full;
    logic [15:0] acc;
    logic [15:0] sh;
    int          n;
    @(negedge clk);
    full = {16'd0, a} * {16'd0, b};
    acc  = 16'd0;
    n    = 0;
    for (int i = 0; i < 16; i++) begin
      if ((b >> i) != 16'd0) begin
        sh = a << i;
        if (b[i]) begin
          alu_q.push_back({3'b000, acc, sh});
          acc = acc + sh;
          n++;
        end
        alu_q.push_back({3'b101, sh, 16'd0});
        n++;
      end
    end
    exp_q.push_back({32'(cyc + 1 + n), |full[31:16], full[15:0]});
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op_a  = 16'($urandom);
    op_b  = 16'($urandom);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!done) begin
      n_checks++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", k);
    end
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    int          k;
    rst_n = 1'b1;
    start = 1'b0;
    op_a  = 16'd0;
    op_b  = 16'd0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_result", 32'(result), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed cases
    issue(16'h0003, 16'h0005); wait_done();
    issue(16'h00FF, 16'h0101); wait_done();
    issue(16'h8000, 16'h0002); wait_done();
    issue(16'hFFFF, 16'hFFFF); wait_done();
    issue(16'h1234, 16'h0000); wait_done();

    // start while busy must be ignored
    issue(16'h0123, 16'h00F0);
    repeat (3) @(negedge clk);
    op_a = 16'hFFFF; op_b = 16'h0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // start during the done cycle must be ignored
    issue(16'h0042, 16'h0000);
    wait_done();
    op_a = 16'hFFFF; op_b = 16'h0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);

    // Randomized operands with a mix of multiplier shapes
    repeat (40) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = 16'($urandom);
        1:       rb = 16'($urandom_range(0, 15));
        2:       rb = 16'd1 << $urandom_range(0, 15);
        default: begin rb = 16'($urandom); ra = 16'($urandom_range(0, 255)); end
      endcase
      issue(ra, rb);
      wait_done();
    end

    // Async reset in the middle of a SHIFT must abort with no done
    issue(16'h0003, 16'h0005); wait_done();
    issue(16'hFFFF, 16'hFFFF);
    k = 0;
    while (alu_op !== 3'b101 && k < 10) begin @(negedge clk); k++; end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_result", 32'(result), 32'd0);
    check("arst_ovf", 32'(ovf), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_alu_a", 32'(alu_a), 32'd0);
    check("arst_alu_b", 32'(alu_b), 32'd0);
    check("arst_alu_op", 32'(alu_op), 32'd0);
    check("arst_alu_cin", 32'(alu_cin), 32'd0);
    exp_q.delete();
    alu_q.delete();
    prev_res = 16'd0;
    prev_ovf = 1'b0;
    @(posedge clk); #1;
    check("arst_busy_held", 32'(busy), 32'd0);
    check("arst_done_held", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    issue(16'h0002, 16'h0003); wait_done();

    repeat (4) @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("alu_q_drained", 32'(alu_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
